// File: rtl/mem_bus_arb.sv
// mem_bus_arb: shares one mem_space port between instruction fetch (IF),
// CPU data (DA) and DMA (DM). Each access runs IDLE -> ADDR -> [DATA] -> IDLE;
// writes ack in ADDR, reads ack in DATA with registered rdata.
// Optional build macro MEM_ARB_RR_EN: DA and DM share round-robin instead of
// fixed DM > DA priority. The IF starvation override applies in both builds.
module mem_bus_arb #(
   parameter int SIZE       = 16,
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            IF_req,
   input  logic [SIZE-1:0] IF_addr,
   input  logic            DA_req,
   input  logic [SIZE-1:0] DA_addr,
   input  logic [SIZE-1:0] DA_wdata,
   input  logic            DA_we,
   input  logic            DA_bw,
   input  logic            DM_req,
   input  logic [SIZE-1:0] DM_addr,
   input  logic [SIZE-1:0] DM_wdata,
   input  logic            DM_we,
   input  logic            DM_bw,
   output logic            IF_gnt,
   output logic            DA_gnt,
   output logic            DM_gnt,
   output logic            IF_ack,
   output logic            DA_ack,
   output logic            DM_ack,
   output logic [SIZE-1:0] rdata,
   output logic [SIZE-1:0] MAB_in,
   output logic [SIZE-1:0] MDB_in,
   output logic            MW,
   output logic            BW,
   input  logic [SIZE-1:0] MDB_out
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   localparam logic [1:0] ID_IF = 2'd0;
   localparam logic [1:0] ID_DA = 2'd1;
   localparam logic [1:0] ID_DM = 2'd2;

   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   // Starvation counter increment that sticks at the limit.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v >= STARVE_LIM) return STARVE_LIM;
      return v + 1'b1;
   endfunction

   logic [1:0]       state_q, state_d;
   logic [1:0]       owner_q, owner_d;
   logic             we_q, we_d;
   logic [SIZE-1:0]  mab_q, mab_d;
   logic [SIZE-1:0]  mdb_q, mdb_d;
   logic             bw_q, bw_d;
   logic [SIZE-1:0]  rdata_q, rdata_d;
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

   logic             win_vld;
   logic [1:0]       win_id;
   logic [SIZE-1:0]  win_addr;
   logic [SIZE-1:0]  win_wdata;
   logic             win_we;
   logic             win_bw;

`ifdef MEM_ARB_RR_EN
   logic             last_dm_q, last_dm_d;
`endif

   // Pick the requester that would win if the arbiter is sampling this edge.
   always_comb begin
      win_vld = IF_req | DA_req | DM_req;
      win_id  = ID_IF;
      if (IF_req && (starve_cnt_q == STARVE_LIM))
         win_id = ID_IF;
`ifdef MEM_ARB_RR_EN
      else if (DA_req && DM_req)
         win_id = last_dm_q ? ID_DA : ID_DM;
`endif
      else if (DM_req)
         win_id = ID_DM;
      else if (DA_req)
         win_id = ID_DA;
      else
         win_id = ID_IF;
   end

   // Route the winner's address and write attributes; fetch is always a word read.
   always_comb begin
      win_addr  = IF_addr;
      win_wdata = '0;
      win_we    = 1'b0;
      win_bw    = 1'b0;
      case (win_id)
         ID_DA: begin
            win_addr  = DA_addr;
            win_wdata = DA_wdata;
            win_we    = DA_we;
            win_bw    = DA_bw;
         end
         ID_DM: begin
            win_addr  = DM_addr;
            win_wdata = DM_wdata;
            win_we    = DM_we;
            win_bw    = DM_bw;
         end
         default: begin
            win_addr  = IF_addr;
            win_wdata = '0;
            win_we    = 1'b0;
            win_bw    = 1'b0;
         end
      endcase
   end

   // Access sequencer: latch the winner in IDLE, drive the bus in ADDR, capture read data into DATA.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      we_d         = we_q;
      mab_d        = mab_q;
      mdb_d        = mdb_q;
      bw_d         = bw_q;
      rdata_d      = rdata_q;
      starve_cnt_d = starve_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (!IF_req || (win_id == ID_IF))
               starve_cnt_d = '0;
            else
               starve_cnt_d = sat_inc(starve_cnt_q);
            if (win_vld) begin
               state_d = ST_ADDR;
               owner_d = win_id;
               we_d    = win_we;
               mab_d   = win_addr;
               bw_d    = win_bw;
               if (win_we)
                  mdb_d = win_wdata;
            end
         end
         ST_ADDR: begin
            if (we_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DATA;
               rdata_d = MDB_out;
            end
         end
         ST_DATA: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Sequencer and bus-holding registers; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= ID_IF;
         we_q         <= 1'b0;
         mab_q        <= '0;
         mdb_q        <= '0;
         bw_q         <= 1'b0;
         rdata_q      <= '0;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         mab_q        <= mab_d;
         mdb_q        <= mdb_d;
         bw_q         <= bw_d;
         rdata_q      <= rdata_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

`ifdef MEM_ARB_RR_EN
   // Remember which of DA/DM was served last so the other wins the next tie.
   always_comb begin
      last_dm_d = last_dm_q;
      if ((state_q == ST_IDLE) && win_vld) begin
         if (win_id == ID_DM)
            last_dm_d = 1'b1;
         else if (win_id == ID_DA)
            last_dm_d = 1'b0;
      end
   end

   // Round-robin history register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_dm_q <= 1'b0;
      else
         last_dm_q <= last_dm_d;
   end
`endif

   logic busy;
   logic done;

   // Grants cover ADDR and DATA; a write completes in ADDR, a read in DATA.
   always_comb begin
      busy   = (state_q != ST_IDLE);
      done   = ((state_q == ST_ADDR) && we_q) || (state_q == ST_DATA);
      IF_gnt = busy && (owner_q == ID_IF);
      DA_gnt = busy && (owner_q == ID_DA);
      DM_gnt = busy && (owner_q == ID_DM);
      IF_ack = done && (owner_q == ID_IF);
      DA_ack = done && (owner_q == ID_DA);
      DM_ack = done && (owner_q == ID_DM);
      MW     = (state_q == ST_ADDR) && we_q;
   end

   assign MAB_in = mab_q;
   assign MDB_in = mdb_q;
   assign BW     = bw_q;
   assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed testbench for mem_bus_arb with a simple word memory behind the bus.
module tb_mem_bus_arb;

   logic        clk;
   logic        rst;
   logic        IF_req;
   logic [15:0] IF_addr;
   logic        DA_req;
   logic [15:0] DA_addr;
   logic [15:0] DA_wdata;
   logic        DA_we;
   logic        DA_bw;
   logic        DM_req;
   logic [15:0] DM_addr;
   logic [15:0] DM_wdata;
   logic        DM_we;
   logic        DM_bw;
   logic        IF_gnt, DA_gnt, DM_gnt;
   logic        IF_ack, DA_ack, DM_ack;
   logic [15:0] rdata;
   logic [15:0] MAB_in;
   logic [15:0] MDB_in;
   logic        MW;
   logic        BW;
   logic [15:0] MDB_out;

   int n_tests;
   int n_fail;

   logic [15:0] mem [0:1023];

   mem_bus_arb #(.SIZE(16), .STARVE_MAX(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .IF_req(IF_req), .IF_addr(IF_addr),
      .DA_req(DA_req), .DA_addr(DA_addr), .DA_wdata(DA_wdata), .DA_we(DA_we), .DA_bw(DA_bw),
      .DM_req(DM_req), .DM_addr(DM_addr), .DM_wdata(DM_wdata), .DM_we(DM_we), .DM_bw(DM_bw),
      .IF_gnt(IF_gnt), .DA_gnt(DA_gnt), .DM_gnt(DM_gnt),
      .IF_ack(IF_ack), .DA_ack(DA_ack), .DM_ack(DM_ack),
      .rdata(rdata), .MAB_in(MAB_in), .MDB_in(MDB_in), .MW(MW), .BW(BW),
      .MDB_out(MDB_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: combinational read, write on the clock edge when MW is high.
   assign MDB_out = mem[MAB_in[9:0]];
   always @(posedge clk) begin
      if (MW) mem[MAB_in[9:0]] <= MDB_in;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic test_reset();
      rst = 1'b0;
      DA_req = 1'b1; DA_addr = 16'h0100; DA_we = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({IF_gnt, DA_gnt, DM_gnt, IF_ack, DA_ack, DM_ack, MW, BW} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 00000000",
                  {IF_gnt, DA_gnt, DM_gnt, IF_ack, DA_ack, DM_ack, MW, BW});
      end
      n_tests++;
      if ({MAB_in, MDB_in, rdata} !== 48'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h/%h/%h expected 0/0/0", MAB_in, MDB_in, rdata);
      end
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({DA_gnt, MW, MAB_in} !== {1'b1, 1'b0, 16'h0100}) begin
         n_fail++;
         $display("FAIL reset_release_addr: got gnt=%b mw=%b mab=%h expected 1 0 0100", DA_gnt, MW, MAB_in);
      end
      DA_req = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({DA_ack, rdata} !== {1'b1, 16'hA100}) begin
         n_fail++;
         $display("FAIL reset_release_read: got ack=%b rdata=%h expected 1 a100", DA_ack, rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_write_read();
      DA_req = 1'b1; DA_we = 1'b1; DA_addr = 16'h0200; DA_wdata = 16'hBEEF; DA_bw = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({MAB_in, MDB_in, MW, DA_ack, DA_gnt} !== {16'h0200, 16'hBEEF, 1'b1, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL write_addr: got mab=%h mdb=%h mw=%b ack=%b gnt=%b expected 0200 beef 1 1 1",
                  MAB_in, MDB_in, MW, DA_ack, DA_gnt);
      end
      n_tests++;
      if (rdata !== 16'hA100) begin
         n_fail++;
         $display("FAIL write_keeps_rdata: got %h expected a100", rdata);
      end
      DA_req = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({MW, DA_ack, DA_gnt} !== 3'b000) begin
         n_fail++;
         $display("FAIL write_idle: got mw/ack/gnt=%b expected 000", {MW, DA_ack, DA_gnt});
      end
      DA_req = 1'b1; DA_we = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({MW, DA_ack, DA_gnt, MAB_in} !== {1'b0, 1'b0, 1'b1, 16'h0200}) begin
         n_fail++;
         $display("FAIL read_addr: got mw=%b ack=%b gnt=%b mab=%h expected 0 0 1 0200",
                  MW, DA_ack, DA_gnt, MAB_in);
      end
      DA_req = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({MW, DA_ack, DA_gnt, rdata} !== {1'b0, 1'b1, 1'b1, 16'hBEEF}) begin
         n_fail++;
         $display("FAIL read_data: got mw=%b ack=%b gnt=%b rdata=%h expected 0 1 1 beef",
                  MW, DA_ack, DA_gnt, rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_starvation();
      logic [2:0] seq [5];
      logic [2:0] exp_seq [5];
      logic [2:0] prev, cur;
      int nrec, drop_if, drop_da, drop_dm;
      exp_seq[0] = 3'b100; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100;
      exp_seq[3] = 3'b010; exp_seq[4] = 3'b001;
      for (int i = 0; i < 5; i++) seq[i] = 3'b000;
      prev = 3'b000; nrec = 0; drop_if = 0; drop_da = 0; drop_dm = 0;
      IF_addr = 16'h0204;
      DA_addr = 16'h0200; DA_we = 1'b0; DA_bw = 1'b0;
      DM_addr = 16'h0300; DM_wdata = 16'h1234; DM_we = 1'b1; DM_bw = 1'b0;
      IF_req = 1'b1; DA_req = 1'b1; DM_req = 1'b1;
      for (int c = 0; c < 60 && nrec < 5; c++) begin
         @(negedge clk);
         cur = {DM_gnt, DA_gnt, IF_gnt};
         if (cur != 3'b000 && prev == 3'b000) begin
            seq[nrec] = cur;
            nrec++;
         end
         prev = cur;
         if (DM_ack) drop_dm = 2;
         if (DA_ack) drop_da = 2;
         if (IF_ack) drop_if = 2;
         DM_req = (drop_dm == 0); if (drop_dm > 0) drop_dm--;
         DA_req = (drop_da == 0); if (drop_da > 0) drop_da--;
         IF_req = (drop_if == 0); if (drop_if > 0) drop_if--;
      end
      IF_req = 1'b0; DA_req = 1'b0; DM_req = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if (seq[i] !== exp_seq[i]) begin
            n_fail++;
            $display("FAIL starve_order[%0d]: got {DM,DA,IF}=%b expected %b", i, seq[i], exp_seq[i]);
         end
      end
   endtask

   task automatic test_da_dm_arb();
      logic [2:0] seq [4];
      logic [2:0] exp_seq [4];
      logic [2:0] prev, cur;
      int nrec;
`ifdef MEM_ARB_RR_EN
      exp_seq[0] = 3'b100; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b010;
`else
      exp_seq[0] = 3'b100; exp_seq[1] = 3'b100; exp_seq[2] = 3'b100; exp_seq[3] = 3'b100;
`endif
      for (int i = 0; i < 4; i++) seq[i] = 3'b000;
      prev = 3'b000; nrec = 0;
      DA_addr = 16'h0200; DA_we = 1'b0;
      DM_addr = 16'h0300; DM_wdata = 16'h5678; DM_we = 1'b1;
      DA_req = 1'b1; DM_req = 1'b1; IF_req = 1'b0;
      for (int c = 0; c < 40 && nrec < 4; c++) begin
         @(negedge clk);
         cur = {DM_gnt, DA_gnt, IF_gnt};
         if (cur != 3'b000 && prev == 3'b000) begin
            seq[nrec] = cur;
            nrec++;
         end
         prev = cur;
      end
      DA_req = 1'b0; DM_req = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (seq[i] !== exp_seq[i]) begin
            n_fail++;
            $display("FAIL da_dm_order[%0d]: got {DM,DA,IF}=%b expected %b", i, seq[i], exp_seq[i]);
         end
      end
   endtask

   task automatic test_byte_write();
      int mw_cnt, ack_cnt;
      logic bw_at, addr_ok, data_ok;
      mw_cnt = 0; ack_cnt = 0; bw_at = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
      DM_addr = 16'h0201; DM_wdata = 16'h00AA; DM_we = 1'b1; DM_bw = 1'b1;
      DM_req = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (MW) begin
            mw_cnt++;
            bw_at   = BW;
            addr_ok = (MAB_in == 16'h0201);
            data_ok = (MDB_in == 16'h00AA);
         end
         if (DM_ack) begin
            ack_cnt++;
            DM_req = 1'b0;
         end
      end
      DM_bw = 1'b0;
      n_tests++;
      if (mw_cnt !== 1) begin
         n_fail++;
         $display("FAIL byte_mw_cycles: got %0d expected 1", mw_cnt);
      end
      n_tests++;
      if ({bw_at, addr_ok, data_ok} !== 3'b111) begin
         n_fail++;
         $display("FAIL byte_bus: got bw/addr_ok/data_ok=%b expected 111", {bw_at, addr_ok, data_ok});
      end
      n_tests++;
      if (ack_cnt !== 1) begin
         n_fail++;
         $display("FAIL byte_ack: got %0d expected 1", ack_cnt);
      end
      n_tests++;
      if ({BW, MW} !== 2'b10) begin
         n_fail++;
         $display("FAIL byte_hold: got bw=%b mw=%b expected 1 0", BW, MW);
      end
      n_tests++;
      if (mem[10'h201] !== 16'h00AA) begin
         n_fail++;
         $display("FAIL byte_mem: got %h expected 00aa", mem[10'h201]);
      end
   endtask

   task automatic test_reset_in_read();
      int ack_cnt;
      ack_cnt = 0;
      IF_addr = 16'h0200;
      IF_req = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({IF_gnt, IF_ack, MAB_in} !== {1'b1, 1'b0, 16'h0200}) begin
         n_fail++;
         $display("FAIL rstread_addr: got gnt=%b ack=%b mab=%h expected 1 0 0200", IF_gnt, IF_ack, MAB_in);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      IF_req = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({IF_gnt, DA_gnt, DM_gnt, IF_ack, MW, rdata} !== {5'b00000, 16'h0000}) begin
         n_fail++;
         $display("FAIL rstread_abort: got gnts/ack/mw=%b rdata=%h expected 00000 0000",
                  {IF_gnt, DA_gnt, DM_gnt, IF_ack, MW}, rdata);
      end
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (IF_ack || IF_gnt) ack_cnt++;
      end
      n_tests++;
      if (ack_cnt !== 0) begin
         n_fail++;
         $display("FAIL rstread_quiet: got %0d active cycles expected 0", ack_cnt);
      end
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 16'hA000 + 16'(i);
      rst = 1'b0;
      IF_req = 1'b0; IF_addr = '0;
      DA_req = 1'b0; DA_addr = '0; DA_wdata = '0; DA_we = 1'b0; DA_bw = 1'b0;
      DM_req = 1'b0; DM_addr = '0; DM_wdata = '0; DM_we = 1'b0; DM_bw = 1'b0;
      @(negedge clk);
      test_reset();
      test_write_read();
      test_starvation();
      test_da_dm_arb();
      test_byte_write();
      test_reset_in_read();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
